// File: rtl/seq_det_arbiter_pkg.sv
// Shared types and defaults for the seq_det_arbiter block.
// Optional build macro SEQ_DET_ARB_FIXED_PRIO_EN is consumed by rr_arb2.
package seq_det_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef logic req_idx_t;

endpackage

// File: rtl/seq_det_arbiter_rr_arb2.sv
// Two-input arbiter: round-robin by default, fixed priority (req0 first)
// when SEQ_DET_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import seq_det_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  input  logic     req0,
  input  logic     req1,
  output logic     gnt0,
  output logic     gnt1,
  output req_idx_t idx
);

`ifdef SEQ_DET_ARB_FIXED_PRIO_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  always_comb begin
    gnt0 = en & req0;
    gnt1 = en & req1 & ~req0;
  end
`else
  req_idx_t last_q;
  req_idx_t last_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    last_d = last_q;
    if (en) begin
      if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
      if (gnt0) begin
        last_d = 1'b0;
      end else if (gnt1) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign idx = gnt1;

endmodule

// File: rtl/seq_det_arbiter.sv
// Arbitrates two requesters, serialises the winning word MSB first on x and
// counts Moore detector hits per requester. See rr_arb2 for SEQ_DET_ARB_FIXED_PRIO_EN.
module seq_det_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              x,
  input  logic              y,
  output logic              busy,
  output logic              done,
  output logic              owner,
  output logic [CNT_W-1:0]  hits0,
  output logic [CNT_W-1:0]  hits1,
  output state_e            state_dbg
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Handshake: a requester holds req until it sees gnt; gnt is a one-cycle
  // pulse in IDLE and data is captured on that same rising edge.

  state_e            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  req_idx_t          owner_q, owner_d;
  logic [CNT_W-1:0]  hits0_q, hits0_d;
  logic [CNT_W-1:0]  hits1_q, hits1_d;
  logic              x_q, x_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic     arb_en;
  logic     arb_gnt0;
  logic     arb_gnt1;
  req_idx_t arb_idx;
  logic     sample_y;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .en   (arb_en),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (arb_gnt0),
    .gnt1 (arb_gnt1),
    .idx  (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    idx_d    = idx_q;
    owner_d  = owner_q;
    hits0_d  = hits0_q;
    hits1_d  = hits1_q;
    sample_y = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_gnt0 || arb_gnt1) begin
          state_d = SHIFT;
          owner_d = arb_idx;
          sr_d    = arb_gnt1 ? data1 : data0;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        sr_d     = {sr_q[DATA_W-2:0], 1'b0};
        idx_d    = idx_q + IDX_W'(1);
        // The first SHIFT cycle still sees y from before the word started.
        sample_y = (idx_q != '0);
        if (idx_q == IDX_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        sample_y = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (sample_y && y) begin
      if (owner_q) begin
        hits1_d = (hits1_q == CNT_MAX) ? hits1_q : hits1_q + CNT_W'(1);
      end else begin
        hits0_d = (hits0_q == CNT_MAX) ? hits0_q : hits0_q + CNT_W'(1);
      end
    end

    // Outputs are decoded from the next state so they leave a flop.
    x_d    = (state_d == SHIFT) ? sr_d[DATA_W-1] : 1'b0;
    busy_d = (state_d != IDLE);
    done_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      owner_q <= 1'b0;
      hits0_q <= '0;
      hits1_q <= '0;
      x_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      owner_q <= owner_d;
      hits0_q <= hits0_d;
      hits1_q <= hits1_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign gnt0      = arb_gnt0;
  assign gnt1      = arb_gnt1;
  assign x         = x_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign owner     = owner_q;
  assign hits0     = hits0_q;
  assign hits1     = hits1_q;
  assign state_dbg = state_q;

endmodule
